rec_tran: RTL and testbench

Receive end of the serial OTN link. It synchronizes the incoming serial bit stream and hunts for the frame alignment signal (FAS). Once locked, it deserializes one frame into bytes for the demapper and checks the frame's parity byte. When ARQ is enabled, it returns a start/ACK/stop sequence on the serial ACK line so the sender can either complete or retransmit.

---
 rtl/rec_tran.sv | 161 ++++++++++++++++
 tb/tb_rec_tran.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rec_tran.sv
// rtl/rec_tran.sv - OTN serial receiver: FAS hunt, byte deserializer, parity check, ARQ ack line
// Frame = 6 FAS bytes, payload, 1 XOR-parity byte; ACK line returns start/result/stop bits.
module rec_tran #(
  parameter int FRAME_BYTES    = 4164,
  parameter int ACK_BIT_CYCLES = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_otn_rx_data,
  output logic       o_otn_tx_ack,
  input  logic       i_arq_en,
  output logic [7:0] o_frame_data,
  output logic       o_frame_data_valid,
  output logic       o_frame_start,
  output logic       o_frame_done,
  output logic       o_frame_ok,
  output logic       o_ack_busy
);

  typedef enum logic [2:0] {HUNT, RECV, CHECK, ACK_START, ACK_BIT, ACK_STOP} state_t;
  localparam logic [47:0] FAS = 48'h282828F6F6F6;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [47:0]            sr_q, sr_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [12:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]             byte_q, byte_d;
  logic [7:0]             par_q, par_d;
  logic [15:0]            ack_cnt_q, ack_cnt_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   start_q, start_d;
  logic                   done_q, done_d;
  logic                   ok_q, ok_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;

  logic        rx_bit;
  logic [47:0] sr_shift;
  logic [7:0]  byte_new;
  logic        byte_full;
  logic        last_byte;
  logic        ack_last;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], i_otn_rx_data};
  assign rx_bit    = sync_q[SYNC_STAGES-1];
  assign sr_shift  = {rx_bit, sr_q[47:1]};
  assign byte_new  = {rx_bit, byte_q[7:1]};
  assign byte_full = (state_q == RECV) && (bit_cnt_q == 3'd7);
  assign last_byte = (byte_cnt_q == 13'(FRAME_BYTES - 1));
  assign ack_last  = (ack_cnt_q == 16'(ACK_BIT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= HUNT;
      sync_q     <= '0;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      byte_q     <= '0;
      par_q      <= '0;
      ack_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      ack_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      ack_cnt_q  <= ack_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:      if (sr_shift == FAS) state_d = RECV;
      RECV:      if (byte_full && last_byte) state_d = CHECK;
      CHECK:     state_d = i_arq_en ? ACK_START : HUNT;
      ACK_START: if (ack_last) state_d = ACK_BIT;
      ACK_BIT:   if (ack_last) state_d = ACK_STOP;
      ACK_STOP:  if (ack_last) state_d = HUNT;
      default:   state_d = HUNT;
    endcase
  end

  always_comb begin
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    byte_d     = byte_q;
    par_d      = par_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    ok_d       = ok_q;
    ack_cnt_d  = (state_d == state_q) ? ack_cnt_q + 16'd1 : 16'd0;
    if (state_q == HUNT) sr_d = sr_shift;
    // A fresh hunt must not reuse bits seen before the previous frame.
    if (state_d == HUNT && state_q != HUNT) sr_d = '0;
    if (state_q == HUNT && state_d == RECV) begin
      start_d    = 1'b1;
      ok_d       = 1'b0;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 13'd6;
      par_d      = 8'd0;
    end
    if (state_q == RECV) begin
      byte_d    = byte_new;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (byte_full) begin
        byte_cnt_d = byte_cnt_q + 13'd1;
        if (last_byte) begin
          done_d = 1'b1;
          ok_d   = (byte_new == par_q);
        end else begin
          data_d  = byte_new;
          valid_d = 1'b1;
          par_d   = par_q ^ byte_new;
        end
      end
    end
  end

  always_comb begin
    ack_d  = 1'b1;
    busy_d = 1'b0;
    case (state_d)
      ACK_START, ACK_STOP: begin ack_d = 1'b0; busy_d = 1'b1; end
      ACK_BIT:             begin ack_d = ok_q; busy_d = 1'b1; end
      default:             begin ack_d = 1'b1; busy_d = 1'b0; end
    endcase
  end

  assign o_otn_tx_ack       = ack_q;
  assign o_frame_data       = data_q;
  assign o_frame_data_valid = valid_q;
  assign o_frame_start      = start_q;
  assign o_frame_done       = done_q;
  assign o_frame_ok         = ok_q;
  assign o_ack_busy         = busy_q;

endmodule

// File: tb/tb_rec_tran.sv
// tb/tb_rec_tran.sv - self-checking bench for rec_tran with a cycle-schedule reference model
// Two receivers share the line: one with 1-cycle ACK bits, one with 4-cycle ACK bits.
`timescale 1ns/1ps
module tb_rec_tran;
  localparam int FB = 300;
  localparam int NP = FB - 7;
  localparam int D  = 3;

  logic clk = 1'b0;
  logic rst, rx, arq;
  logic       ack1, val1, st1, dn1, ok1, bsy1;
  logic       ack4, val4, st4, dn4, ok4, bsy4;
  logic [7:0] data1, data4;

  rec_tran #(.FRAME_BYTES(FB), .ACK_BIT_CYCLES(1), .SYNC_STAGES(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_otn_rx_data(rx), .o_otn_tx_ack(ack1), .i_arq_en(arq),
    .o_frame_data(data1), .o_frame_data_valid(val1), .o_frame_start(st1),
    .o_frame_done(dn1), .o_frame_ok(ok1), .o_ack_busy(bsy1));

  rec_tran #(.FRAME_BYTES(FB), .ACK_BIT_CYCLES(4), .SYNC_STAGES(2)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_otn_rx_data(rx), .o_otn_tx_ack(ack4), .i_arq_en(arq),
    .o_frame_data(data4), .o_frame_data_valid(val4), .o_frame_start(st4),
    .o_frame_done(dn4), .o_frame_ok(ok4), .o_ack_busy(bsy4));

  always #5 clk = ~clk;

  int P = 0;
  always @(posedge clk) P <= P + 1;

  // Expected events keyed by cycle number; absent key means idle value.
  bit         exp_start[int];
  logic [7:0] exp_valid[int];
  bit         exp_done[int];
  bit         exp_ack1[int];
  bit         exp_ack4[int];

  int n_vec = 0, n_err = 0;
  bit mok = 1'b0;
  bit chk_en = 1'b0;
  int nvalid = 0, start_cyc = 0, done_cyc = 0, busy4_n = 0, post = 0;
  logic [3:0] seq1 = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, P, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_start.exists(P)) mok = 1'b0;
      if (exp_done.exists(P)) mok = exp_done[P];
      chk("start1", st1, exp_start.exists(P));
      chk("start4", st4, exp_start.exists(P));
      chk("valid1", val1, exp_valid.exists(P));
      chk("valid4", val4, exp_valid.exists(P));
      if (exp_valid.exists(P)) begin
        chk("data1", data1, exp_valid[P]);
        chk("data4", data4, exp_valid[P]);
      end
      chk("done1", dn1, exp_done.exists(P));
      chk("done4", dn4, exp_done.exists(P));
      chk("ok1", ok1, mok);
      chk("ok4", ok4, mok);
      chk("ack1", ack1, exp_ack1.exists(P) ? exp_ack1[P] : 1'b1);
      chk("busy1", bsy1, exp_ack1.exists(P));
      chk("ack4", ack4, exp_ack4.exists(P) ? exp_ack4[P] : 1'b1);
      chk("busy4", bsy4, exp_ack4.exists(P));
      if (st1) begin nvalid = 0; start_cyc = P; busy4_n = 0; end
      if (val1) nvalid++;
      if (bsy4) busy4_n++;
      if (post > 0) begin seq1 = {seq1[2:0], ack1}; post--; end
      if (dn1) begin done_cyc = P; post = 4; end
    end
  end

  function automatic logic [7:0] frame_par();
    logic [7:0] p = 8'h00;
    for (int k = 0; k < NP; k++) p ^= 8'(k % 256);
    return p;
  endfunction

  task automatic drive(input logic b);
    @(negedge clk);
    rx = b;
  endtask

  task automatic drive_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) drive(v[i]);
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) drive(rnd ? logic'($urandom_range(0, 1)) : 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    exp_start.delete(); exp_valid.delete(); exp_done.delete();
    exp_ack1.delete(); exp_ack4.delete();
    mok = 1'b0;
    #1;
    chk("rst_ack", {ack1, ack4}, 2'b11);
    chk("rst_data", {data1, data4}, 16'h0);
    chk("rst_strobes", {val1, st1, dn1, val4, st4, dn4}, 6'h0);
    chk("rst_ok_busy", {ok1, bsy1, ok4, bsy4}, 4'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_ack(input int t, input int a, input bit ok, input bit four);
    for (int i = 1; i <= a; i++) begin
      if (four) begin
        exp_ack4[t + i] = 1'b0; exp_ack4[t + a + i] = ok; exp_ack4[t + 2*a + i] = 1'b0;
      end else begin
        exp_ack1[t + i] = 1'b0; exp_ack1[t + a + i] = ok; exp_ack1[t + 2*a + i] = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input int corrupt, input int abort_at);
    logic [7:0] fas [6];
    logic [7:0] par, txpar, v, tx;
    int n, t;
    fas = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28};
    for (int i = 0; i < 6; i++) drive_byte(fas[i]);
    n = P;
    exp_start[n + D] = 1'b1;
    par = 8'h00; txpar = 8'h00;
    for (int k = 0; k < NP; k++) begin
      if (k == abort_at) begin
        do_reset();
        return;
      end
      v  = 8'(k % 256);
      tx = (k == corrupt) ? (v ^ 8'h08) : v;
      par ^= v; txpar ^= tx;
      drive_byte(tx);
      exp_valid[n + 8*(k+1) + D] = tx;
    end
    drive_byte(par);
    t = n + 8*(NP+1) + D;
    exp_done[t] = (txpar == par);
    if (arq) begin
      set_ack(t, 1, txpar == par, 1'b0);
      set_ack(t, 4, txpar == par, 1'b1);
    end
    idle(28, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; arq = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    do_reset();
    idle(200, 1'b0);
    chk("model_parity", frame_par(), 8'h24);

    arq = 1'b1;
    idle(10, 1'b1);
    send_frame(-1, -1);
    chk("pin_nvalid", nvalid, 293);
    chk("pin_latency", done_cyc - start_cyc, 2352);
    chk("pin_ack_good", seq1, 4'b0101);
    chk("pin_busy4", busy4_n, 12);

    send_frame(100, -1);
    chk("pin_ack_bad", seq1, 4'b0001);
    send_frame(-1, -1);
    chk("pin_ack_retx", seq1, 4'b0101);

    arq = 1'b0;
    send_frame(-1, -1);
    chk("pin_noarq_busy4", busy4_n, 0);

    idle(37, 1'b1);
    drive_byte(8'hF6); drive_byte(8'hF6); drive_byte(8'hF6);
    drive_byte(8'h28); drive_byte(8'h28); drive_byte(8'h00);
    idle(20, 1'b0);
    idle(3, 1'b1);
    send_frame(-1, -1);
    chk("pin_align_nvalid", nvalid, 293);

    arq = 1'b1;
    send_frame(-1, 200);
    idle(20, 1'b1);
    send_frame(-1, -1);
    chk("pin_after_rst_ack", seq1, 4'b0101);
    chk("pin_after_rst_nvalid", nvalid, 293);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
